// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first) with a start/busy/done handshake.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered signed-overflow output.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrowOut
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] difference_q, difference_d;
    logic             borrow_out_q, borrow_out_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             overflow_q, overflow_d;
`endif

    // Full-subtractor cell on the current LSBs.
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_shift;

    assign d_bit     = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    assign br_next   = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
    assign res_shift = {d_bit, res_q[WIDTH-1:1]};

    // Next-state and datapath control.
    always_comb begin
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        res_d        = res_q;
        br_d         = br_q;
        cnt_d        = cnt_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        difference_d = difference_q;
        borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        overflow_d   = overflow_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                res_d  = res_shift;
                br_d   = br_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    difference_d = res_shift;
                    borrow_out_d = br_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    // On the last shift the operand LSBs are the original MSBs.
                    overflow_d   = (a_sr_q[0] != b_sr_q[0]) && (d_bit != a_sr_q[0]);
`endif
                    done_d       = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            res_q        <= '0;
            br_q         <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            difference_q <= '0;
            borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            overflow_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            res_q        <= res_d;
            br_q         <= br_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            difference_q <= difference_d;
            borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            overflow_q   <= overflow_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign difference = difference_q;
    assign borrowOut  = borrow_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign overflow   = overflow_q;
`endif

endmodule
